// File: rtl/alu_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_stage_pkg : shared opcodes, flag indices, conditions and FIFO entry     |
// | Revision      : 1.0                                                         |
// +----------------------------------------------------------------------------+
package alu_stage_pkg;

   localparam int DEST_W     = 3;
   localparam int FLAG_W     = 4;
   localparam int PKG_DATA_W = 8;

   typedef enum logic [3:0] {
      OP_AND  = 4'h0,
      OP_OR   = 4'h1,
      OP_XOR  = 4'h2,
      OP_NOT  = 4'h3,
      OP_INC  = 4'h4,
      OP_DCR  = 4'h5,
      OP_ROL  = 4'h6,
      OP_ROR  = 4'h7,
      OP_ADD  = 4'h8,
      OP_ADC  = 4'h9,
      OP_SUB  = 4'hA,
      OP_SBC  = 4'hB,
      OP_PASS = 4'hC,
      OP_CLR  = 4'hD,
      OP_SHL  = 4'hE,
      OP_SHR  = 4'hF
   } s_af_op_e;

   localparam int FLG_Z   = 0;
   localparam int FLG_C   = 1;
   localparam int FLG_P   = 2;
   localparam int FLG_PAR = 3;

   typedef enum logic [2:0] {
      COND_ALWAYS = 3'd0,
      COND_Z      = 3'd1,
      COND_NZ     = 3'd2,
      COND_C      = 3'd3,
      COND_NC     = 3'd4,
      COND_P      = 3'd5,
      COND_NP     = 3'd6,
      COND_ODD    = 3'd7
   } cond_sel_e;

   typedef struct packed {
      logic [PKG_DATA_W-1:0] data;
      logic [DEST_W-1:0]     dest;
   } alu_entry_t;

   // Only INC..SBC produce an architecturally meaningful carry.
   function automatic logic op_writes_carry(input logic [3:0] op);
      return (op >= OP_INC) && (op <= OP_SBC);
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_result_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_result_fifo : DEPTH-entry result storage with occupancy state machine   |
// | Revision        : 1.0                                                       |
// +----------------------------------------------------------------------------+
module alu_result_fifo #(
   parameter int DEPTH   = 2,
   parameter int ENTRY_W = 11
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [ENTRY_W-1:0]         push_entry,
   output logic [ENTRY_W-1:0]         head_entry,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      OCC_EMPTY   = 2'd0,
      OCC_PARTIAL = 2'd1,
      OCC_FULL    = 2'd2
   } occ_state_e;

   occ_state_e          r_state;
   occ_state_e          w_state_next;
   logic [CNT_W-1:0]    r_count;
   logic [CNT_W-1:0]    w_count_next;
   logic [PTR_W-1:0]    r_wr_ptr;
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [ENTRY_W-1:0]  r_mem [DEPTH];
   logic                w_push;
   logic                w_pop;

   assign w_push = push & (r_state != OCC_FULL);
   assign w_pop  = pop  & (r_state != OCC_EMPTY);

   always_comb begin
      w_count_next = r_count;
      w_state_next = r_state;
      case ({w_push, w_pop})
         2'b10:   w_count_next = r_count + CNT_W'(1);
         2'b01:   w_count_next = r_count - CNT_W'(1);
         default: w_count_next = r_count;
      endcase
      case (r_state)
         OCC_EMPTY: begin
            if (w_push) w_state_next = OCC_PARTIAL;
         end
         OCC_PARTIAL: begin
            if (w_push && !w_pop && (r_count == CNT_W'(DEPTH - 1)))
               w_state_next = OCC_FULL;
            else if (w_pop && !w_push && (r_count == CNT_W'(1)))
               w_state_next = OCC_EMPTY;
         end
         OCC_FULL: begin
            if (w_pop) w_state_next = OCC_PARTIAL;
         end
         default: w_state_next = OCC_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= OCC_EMPTY;
         r_count  <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         r_state <= w_state_next;
         r_count <= w_count_next;
         // Power-of-two depth lets the pointers wrap by natural overflow.
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= push_entry;
   end

   assign empty      = (r_state == OCC_EMPTY);
   assign full       = (r_state == OCC_FULL);
   assign count      = r_count;
   assign head_entry = empty ? '0 : r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/alu_result_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_result_stage : ALU result buffer, flag register and branch condition    |
// | Optional same-cycle bypass with ALU_RES_BYPASS_EN.  Revision : 1.0          |
// +----------------------------------------------------------------------------+
module alu_result_stage
   import alu_stage_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [WIDTH-1:0]          alu_out,
   input  logic [3:0]                alu_flags,
   input  logic [3:0]                alu_op,
   input  logic                      in_valid,
   input  logic [2:0]                in_dest,
   input  logic                      in_flag_we,
   output logic                      in_ready,
   output logic                      wb_valid,
   input  logic                      wb_ready,
   output logic [WIDTH-1:0]          wb_data,
   output logic [2:0]                wb_dest,
   output logic [3:0]                flags,
   output logic                      cin,
   input  logic [2:0]                cond_sel,
   output logic                      cond_true,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int ENTRY_W = WIDTH + DEST_W;

   logic                r_[0:0];
   logic [FLAG_W-1:0]   r_flags;
   logic [ENTRY_W-1:0]  w_head;
   logic                w_fifo_full;
   logic                w_fifo_empty;
   logic                w_accept;
   logic                w_push;
   logic                w_pop;
   logic                w_cond;

   assign in_ready = ~w_fifo_full;
   assign w_accept = in_valid & in_ready;
   assign w_pop    = ~w_fifo_empty & wb_ready;

`ifdef ALU_RES_BYPASS_EN
   logic w_bypass;

   // An empty FIFO with a ready consumer forwards the input without storing it.
   assign w_bypass = w_fifo_empty & wb_ready & in_valid;
   assign w_push   = w_accept & ~w_bypass;
   assign wb_valid = ~w_fifo_empty | w_bypass;
   assign {wb_data, wb_dest} = w_bypass ? {alu_out, in_dest} : w_head;
`else
   assign w_push   = w_accept;
   assign wb_valid = ~w_fifo_empty;
   assign {wb_data, wb_dest} = w_head;
`endif

   alu_result_fifo #(
      .DEPTH   (DEPTH),
      .ENTRY_W (ENTRY_W)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (w_push),
      .pop        (w_pop),
      .push_entry ({alu_out, in_dest}),
      .head_entry (w_head),
      .count      (count),
      .full       (w_fifo_full),
      .empty      (w_fifo_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_flags <= '0;
      end else if (w_accept && in_flag_we) begin
         r_flags[FLG_Z]   <= alu_flags[FLG_Z];
         r_flags[FLG_P]   <= alu_flags[FLG_P];
         r_flags[FLG_PAR] <= alu_flags[FLG_PAR];
         if (op_writes_carry(alu_op)) r_flags[FLG_C] <= alu_flags[FLG_C];
      end
   end

   always_comb begin
      w_cond = 1'b1;
      case (cond_sel_e'(cond_sel))
         COND_ALWAYS: w_cond = 1'b1;
         COND_Z:      w_cond = r_flags[FLG_Z];
         COND_NZ:     w_cond = ~r_flags[FLG_Z];
         COND_C:      w_cond = r_flags[FLG_C];
         COND_NC:     w_cond = ~r_flags[FLG_C];
         COND_P:      w_cond = r_flags[FLG_P];
         COND_NP:     w_cond = ~r_flags[FLG_P];
         COND_ODD:    w_cond = r_flags[FLG_PAR];
         default:     w_cond = 1'b1;
      endcase
   end

   assign flags     = r_flags;
   assign cin       = r_flags[FLG_C];
   assign cond_true = w_cond;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu_result_stage : self-checking bench with queue-based reference model  |
// | Revision            : 1.0                                                   |
// +----------------------------------------------------------------------------+
module tb_alu_result_stage;
   import alu_stage_pkg::*;

   localparam int DEPTH = 2;
   localparam int WIDTH = 8;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [WIDTH-1:0] alu_out;
   logic [3:0]       alu_flags;
   logic [3:0]       alu_op;
   logic             in_valid;
   logic [2:0]       in_dest;
   logic             in_flag_we;
   logic             in_ready;
   logic             wb_valid;
   logic             wb_ready;
   logic [WIDTH-1:0] wb_data;
   logic [2:0]       wb_dest;
   logic [3:0]       flags;
   logic             cin;
   logic [2:0]       cond_sel;
   logic             cond_true;
   logic [CW-1:0]    count;

   int total = 0;
   int bad   = 0;

   alu_entry_t q[$];
   logic [3:0] mflags;

   alu_result_stage #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n), .alu_out(alu_out), .alu_flags(alu_flags),
      .alu_op(alu_op), .in_valid(in_valid), .in_dest(in_dest),
      .in_flag_we(in_flag_we), .in_ready(in_ready), .wb_valid(wb_valid),
      .wb_ready(wb_ready), .wb_data(wb_data), .wb_dest(wb_dest),
      .flags(flags), .cin(cin), .cond_sel(cond_sel), .cond_true(cond_true),
      .count(count)
   );

   always #5 clk = ~clk;

   function automatic logic m_bypass();
`ifdef ALU_RES_BYPASS_EN
      return (q.size() == 0) && wb_ready && in_valid;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic m_wb_valid();
      return (q.size() != 0) || m_bypass();
   endfunction

   function automatic logic [WIDTH-1:0] m_wb_data();
      if (q.size() != 0) return q[0].data;
      if (m_bypass()) return alu_out;
      return '0;
   endfunction

   function automatic logic [2:0] m_wb_dest();
      if (q.size() != 0) return q[0].dest;
      if (m_bypass()) return in_dest;
      return '0;
   endfunction

   function automatic logic m_cond(input logic [2:0] sel);
      case (sel)
         3'd0: return 1'b1;
         3'd1: return mflags[0];
         3'd2: return !mflags[0];
         3'd3: return mflags[1];
         3'd4: return !mflags[1];
         3'd5: return mflags[2];
         3'd6: return !mflags[2];
         default: return mflags[3];
      endcase
   endfunction

   task automatic drive_idle();
      in_valid = 0; in_flag_we = 0; wb_ready = 0; alu_out = '0;
      alu_flags = '0; alu_op = '0; in_dest = '0; cond_sel = '0;
   endtask

   // One clock with the currently driven inputs; the model follows the rules directly.
   task automatic tick();
      logic acc, byp, pop_m;
      alu_entry_t e;
      acc   = in_valid && (q.size() < DEPTH);
      byp   = m_bypass();
      pop_m = (q.size() != 0) && wb_ready;
      e.data = alu_out;
      e.dest = in_dest;
      if (acc && in_flag_we) begin
         mflags[0] = alu_flags[0];
         mflags[2] = alu_flags[2];
         mflags[3] = alu_flags[3];
         if (alu_op >= 4'h4 && alu_op <= 4'hB) mflags[1] = alu_flags[1];
      end
      @(posedge clk); #1;
      if (pop_m) void'(q.pop_front());
      if (acc && !byp) q.push_back(e);
   endtask

   task automatic test_reset();
      drive_idle();
      rst_n = 0;
      q.delete(); mflags = '0;
      repeat (2) @(posedge clk);
      #1;
      total++; if (count !== '0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
      total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid); end
      total++; if (flags !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", flags); end
      total++; if (cin !== 1'b0) begin bad++; $display("FAIL reset_cin got=%b exp=0", cin); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      total++; if ({wb_data, wb_dest} !== '0) begin bad++; $display("FAIL reset_wb_bus got=%h/%0d exp=0/0", wb_data, wb_dest); end
      rst_n = 1;
      tick();
   endtask

   task automatic test_fill_and_drain();
      wb_ready = 0; in_valid = 1; alu_out = 8'h3C; in_dest = 3'd5;
      tick();
      total++; if (count !== CW'(1)) begin bad++; $display("FAIL fill_count1 got=%0d exp=1", count); end
      total++; if (wb_valid !== 1'b1 || wb_data !== 8'h3C || wb_dest !== 3'd5) begin
         bad++; $display("FAIL fill_head1 got=%b/%h/%0d exp=1/3c/5", wb_valid, wb_data, wb_dest); end
      tick();
      total++; if (count !== CW'(2)) begin bad++; $display("FAIL fill_count2 got=%0d exp=2", count); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
      alu_out = 8'h77; in_dest = 3'd1;
      tick();
      total++; if (count !== CW'(2)) begin bad++; $display("FAIL blocked_push_count got=%0d exp=2", count); end
      total++; if (wb_data !== 8'h3C || wb_dest !== 3'd5) begin
         bad++; $display("FAIL stall_stable got=%h/%0d exp=3c/5", wb_data, wb_dest); end
      in_valid = 0; wb_ready = 1;
      tick();
      total++; if (count !== CW'(1) || wb_data !== 8'h3C || wb_dest !== 3'd5) begin
         bad++; $display("FAIL drain1 got=%0d/%h/%0d exp=1/3c/5", count, wb_data, wb_dest); end
      tick();
      total++; if (count !== '0 || wb_valid !== 1'b0 || wb_data !== '0) begin
         bad++; $display("FAIL drain2 got=%0d/%b/%h exp=0/0/0", count, wb_valid, wb_data); end
   endtask

   task automatic test_push_pop_wrap();
      wb_ready = 0; in_valid = 1; alu_out = 8'h10; in_dest = 3'd0;
      tick();
      wb_ready = 1;
      for (int i = 0; i < 6; i++) begin
         logic [WIDTH-1:0] exp_d;
         logic [2:0]       exp_dst;
         exp_d   = m_wb_data();
         exp_dst = m_wb_dest();
         alu_out = WIDTH'($urandom); in_dest = 3'($urandom);
         #1;
         total++; if (wb_data !== exp_d || wb_dest !== exp_dst) begin
            bad++; $display("FAIL wrap_order[%0d] got=%h/%0d exp=%h/%0d", i, wb_data, wb_dest, exp_d, exp_dst); end
         tick();
         total++; if (count !== CW'(1)) begin bad++; $display("FAIL wrap_count[%0d] got=%0d exp=1", i, count); end
      end
      in_valid = 0;
      tick();
   endtask

   task automatic test_carry_rules();
      in_valid = 1; wb_ready = 1; in_flag_we = 1;
      alu_op = OP_ADD; alu_flags = 4'b0010; alu_out = 8'h01;
      tick();
      total++; if (flags !== 4'b0010 || cin !== 1'b1) begin
         bad++; $display("FAIL carry_add got=%b/%b exp=0010/1", flags, cin); end
      alu_op = OP_AND; alu_flags = 4'b0000;
      tick();
      total++; if (flags !== 4'b0010 || cin !== 1'b1) begin
         bad++; $display("FAIL carry_and_keep got=%b/%b exp=0010/1", flags, cin); end
      alu_op = OP_SUB; alu_flags = 4'b1000;
      tick();
      total++; if (flags !== 4'b1000 || cin !== 1'b0) begin
         bad++; $display("FAIL carry_sub got=%b/%b exp=1000/0", flags, cin); end
      alu_op = OP_INC; alu_flags = 4'b0110; in_flag_we = 0;
      tick();
      total++; if (flags !== 4'b1000) begin
         bad++; $display("FAIL flag_we_off got=%b exp=1000", flags); end
      in_valid = 0;
      tick();
   endtask

   task automatic test_conditions();
      logic [2:0] sels [8]    = '{3'd1, 3'd2, 3'd5, 3'd7, 3'd0, 3'd3, 3'd4, 3'd6};
      logic       expect_c[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      in_valid = 1; in_flag_we = 1; wb_ready = 1; alu_op = OP_XOR; alu_flags = 4'b0101;
      tick();
      in_valid = 0; in_flag_we = 0;
      total++; if (flags !== 4'b0101) begin bad++; $display("FAIL cond_setup got=%b exp=0101", flags); end
      for (int i = 0; i < 8; i++) begin
         cond_sel = sels[i];
         #1;
         total++; if (cond_true !== expect_c[i]) begin
            bad++; $display("FAIL cond_sel%0d got=%b exp=%b", sels[i], cond_true, expect_c[i]); end
      end
      tick();
   endtask

   task automatic test_reset_mid();
      wb_ready = 0; in_valid = 1; in_flag_we = 1; alu_op = OP_ADD; alu_flags = 4'b1111;
      alu_out = 8'h5A; in_dest = 3'd2;
      tick();
      tick();
      total++; if (count !== CW'(2) || wb_valid !== 1'b1 || flags !== 4'b1111) begin
         bad++; $display("FAIL mid_setup got=%0d/%b/%b exp=2/1/1111", count, wb_valid, flags); end
      in_valid = 0; in_flag_we = 0;
      rst_n = 0;
      #1;
      total++; if (wb_valid !== 1'b0 || count !== '0 || flags !== 4'b0000 || in_ready !== 1'b1) begin
         bad++; $display("FAIL mid_reset got=%b/%0d/%b/%b exp=0/0/0000/1", wb_valid, count, flags, in_ready); end
      q.delete(); mflags = '0;
      #2;
      rst_n = 1;
      tick();
   endtask

   task automatic test_bypass_latency();
      wb_ready = 1; in_valid = 1; alu_out = 8'hA5; in_dest = 3'd3; in_flag_we = 0;
      #1;
`ifdef ALU_RES_BYPASS_EN
      total++; if (wb_valid !== 1'b1 || wb_data !== 8'hA5) begin
         bad++; $display("FAIL bypass_same_cycle got=%b/%h exp=1/a5", wb_valid, wb_data); end
`else
      total++; if (wb_valid !== 1'b0 || wb_data !== 8'h00) begin
         bad++; $display("FAIL nobypass_same_cycle got=%b/%h exp=0/00", wb_valid, wb_data); end
`endif
      tick();
      in_valid = 0;
      #1;
`ifdef ALU_RES_BYPASS_EN
      total++; if (count !== '0 || wb_valid !== 1'b0) begin
         bad++; $display("FAIL bypass_not_stored got=%0d/%b exp=0/0", count, wb_valid); end
`else
      total++; if (count !== CW'(1) || wb_valid !== 1'b1 || wb_data !== 8'hA5 || wb_dest !== 3'd3) begin
         bad++; $display("FAIL latency1 got=%0d/%b/%h/%0d exp=1/1/a5/3", count, wb_valid, wb_data, wb_dest); end
`endif
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         in_valid   = 1'($urandom);
         wb_ready   = ($urandom_range(0, 3) != 0);
         alu_out    = WIDTH'($urandom);
         in_dest    = 3'($urandom);
         alu_flags  = 4'($urandom);
         alu_op     = 4'($urandom_range(0, 15));
         in_flag_we = 1'($urandom);
         cond_sel   = 3'($urandom);
         #1;
         total++; if (count !== CW'(q.size()) || in_ready !== (q.size() < DEPTH)) begin
            bad++; $display("FAIL rnd_occ[%0d] got=%0d/%b exp=%0d/%b", i, count, in_ready, q.size(), q.size() < DEPTH); end
         total++; if (wb_valid !== m_wb_valid() || wb_data !== m_wb_data() || wb_dest !== m_wb_dest()) begin
            bad++; $display("FAIL rnd_wb[%0d] got=%b/%h/%0d exp=%b/%h/%0d", i, wb_valid, wb_data, wb_dest,
                            m_wb_valid(), m_wb_data(), m_wb_dest()); end
         total++; if (flags !== mflags || cin !== mflags[1] || cond_true !== m_cond(cond_sel)) begin
            bad++; $display("FAIL rnd_flags[%0d] got=%b/%b/%b exp=%b/%b/%b", i, flags, cin, cond_true,
                            mflags, mflags[1], m_cond(cond_sel)); end
         tick();
      end
      drive_idle();
      wb_ready = 1;
      repeat (DEPTH + 1) tick();
      total++; if (count !== '0) begin bad++; $display("FAIL rnd_drain got=%0d exp=0", count); end
   endtask

   initial begin
      rst_n = 0;
      drive_idle();
      test_reset();
      test_fill_and_drain();
      test_push_pop_wrap();
      test_carry_rules();
      test_conditions();
      test_reset_mid();
      test_bypass_latency();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
